// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for pipeline-stage registers: occupancy state encoding
// and the default NOP bubble also used by hazard-unit code.
package pipe_skid_reg_pkg;

  // Encoding equals the number of held entries, so OCC is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // All-zero word is the MIPS NOP (sll $0,$0,0).
  localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit storage register with load enable and a synchronous
// load-constant input that takes priority over a normal load.
module pipe_data_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CONST_VAL = '0
) (
  input  logic             CLK,
  input  logic             i_const,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (i_const) begin
      r_q <= CONST_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and a programmable bubble value on empty.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_BUBBLE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       OCC
);

  state_e r_state;
  state_e w_state_next;
  logic   r_in_ready;
  logic   r_out_valid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_clear;
  logic w_main_load;
  logic w_main_from_skid;
  logic w_main_bubble;
  logic w_skid_load;
  logic w_skid_bubble;

  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_fire  = IN_VALID & r_in_ready;
  assign w_out_fire = r_out_valid & OUT_READY;
  assign w_clear    = RST | FLUSH;

  always_comb begin
    w_state_next     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_bubble    = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_bubble    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next = ST_ONE;
          w_main_load  = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = ST_FULL;
          w_skid_load  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next  = ST_EMPTY;
          w_main_bubble = 1'b1;
        end
      end
      ST_FULL: begin
        // IN_READY is low here, so only the drain path can happen.
        if (w_out_fire) begin
          w_state_next     = ST_ONE;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_bubble    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // Handshake flags are re-derived from the next state so that both come
  // straight out of flops with no path from OUT_READY.
  always_ff @(posedge CLK) begin
    if (w_clear) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != ST_FULL);
      r_out_valid <= (w_state_next != ST_EMPTY);
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : IN_DATA;

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .CONST_VAL(BUBBLE_VAL)
  ) u_main (
    .CLK    (CLK),
    .i_const(w_clear | w_main_bubble),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .CONST_VAL(BUBBLE_VAL)
  ) u_skid (
    .CLK    (CLK),
    .i_const(w_clear | w_skid_bubble),
    .i_load (w_skid_load),
    .i_d    (IN_DATA),
    .o_q    (w_skid_q)
  );

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = w_main_q;
  assign OCC       = r_state;

endmodule
